des_key_scheduler: RTL

DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

---
 rtl/des_key_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/des_key_scheduler.sv
// DES key schedule: PC1 load on start, one PC2 round key per handshake, K1..K16 or K16..K1.
// C/D rotate in place so the decrypt direction needs no precomputation pass.
module des_key_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] key_high,
  input  logic [31:0] key_low,
  input  logic        decrypt,
  input  logic        start,
  input  logic        key_ready,
  output logic [47:0] round_key,
  output logic [3:0]  round_num,
  output logic        key_valid,
  output logic        busy,
  output logic        done
);

  // Tables hold FIPS 46-3 bit positions, 1 = MSB of the source vector.
  localparam logic [6:0] Pc1Tab [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34,
    7'd26, 7'd18, 7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37,
    7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [6:0] Pc2Tab [48] = '{
    7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,  7'd3,  7'd28, 7'd15, 7'd6,  7'd21, 7'd10,
    7'd23, 7'd19, 7'd12, 7'd4,  7'd26, 7'd8,  7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,
    7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55, 7'd30, 7'd40, 7'd51, 7'd45, 7'd33, 7'd48,
    7'd44, 7'd49, 7'd39, 7'd56, 7'd34, 7'd53, 7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32
  };

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e      state_q;
  logic [55:0] cd_q;
  logic [3:0]  round_q;
  logic        dir_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic [63:0] key_in;
  logic [55:0] pc1_out;
  logic [55:0] cd_load;
  logic [55:0] cd_step;
  logic [47:0] pc2_out;
  logic        step_two;

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  assign key_in = {key_high, key_low};

  always_comb begin
    pc1_out = '0;
    for (int j = 0; j < 56; j++) begin
      pc1_out[55-j] = key_in[6'(7'd64 - Pc1Tab[j])];
    end
  end

  always_comb begin
    pc2_out = '0;
    for (int j = 0; j < 48; j++) begin
      pc2_out[47-j] = cd_q[6'(7'd56 - Pc2Tab[j])];
    end
  end

  // C16/D16 equals C0/D0, so decrypt loads PC1 unrotated and walks backwards.
  assign cd_load = decrypt ? pc1_out : {rotl(pc1_out[55:28], 1'b0), rotl(pc1_out[27:0], 1'b0)};

  // Single-bit steps fall on rounds 0, 7 and 14 in both directions.
  assign step_two = !((round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14));

  assign cd_step = dir_q ? {rotr(cd_q[55:28], step_two), rotr(cd_q[27:0], step_two)}
                         : {rotl(cd_q[55:28], step_two), rotl(cd_q[27:0], step_two)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cd_q    <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StIssue;
            dir_q   <= decrypt;
            cd_q    <= cd_load;
            round_q <= 4'd0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StIssue: begin
          if (key_ready) begin
            if (round_q == 4'd15) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              round_q <= round_q + 4'd1;
              cd_q    <= cd_step;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign round_key = pc2_out;
  assign round_num = round_q;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
